// File: rtl/rel_psum_gbf_packer.sv
// Drains every psum RF address of the PE array into GBF-width words for the
// all-relevant case (no reduction), streaming them into a double-buffered psum GBF.
module rel_psum_gbf_packer #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int GBF_ADDR_BITWIDTH     = 5,
  parameter int DEPTH                 = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_BITWIDTH*ROW*COL-1:0]     psum_out,
  input  logic                                 pe_psum_finish,
  input  logic                                 conv_finish,
  output logic [PSUM_RF_ADDR_BITWIDTH-1:0]     psum_rf_addr,
  output logic                                 su_add_finish,
  output logic [GBF_DATA_BITWIDTH-1:0]         out_data,
  output logic                                 psum_gbf_w_en_out,
  output logic [GBF_ADDR_BITWIDTH-1:0]         psum_gbf_w_addr,
  output logic                                 psum_gbf_w_num
);

  localparam int NCH     = DATA_BITWIDTH * ROW * COL / GBF_DATA_BITWIDTH;
  localparam int CHUNK_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CHUNK_W-1:0]               LAST_CHUNK = CHUNK_W'(NCH - 1);
  localparam logic [PSUM_RF_ADDR_BITWIDTH-1:0] LAST_RF    = '1;
  localparam logic [GBF_ADDR_BITWIDTH-1:0]     LAST_WP    = GBF_ADDR_BITWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                              state_q;
  logic [PSUM_RF_ADDR_BITWIDTH-1:0]    rfAddr_q;
  logic [CHUNK_W-1:0]                  chunk_q;
  logic [GBF_ADDR_BITWIDTH-1:0]        wp_q;
  logic [GBF_ADDR_BITWIDTH-1:0]        wp_d;
  logic [GBF_DATA_BITWIDTH-1:0]        outData_q;
  logic                                wEn_q;
  logic [GBF_ADDR_BITWIDTH-1:0]        wAddr_q;
  logic                                wNum_q;
  logic                                finish_q;
  logic                                lastWrite_q;

  logic [GBF_DATA_BITWIDTH-1:0]        chunkWords [NCH];
  logic [GBF_DATA_BITWIDTH-1:0]        chunkWord;

  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    assign chunkWords[c] = psum_out[c*GBF_DATA_BITWIDTH +: GBF_DATA_BITWIDTH];
  end

  always_comb begin
    chunkWord = chunkWords[chunk_q];
    wp_d      = (wp_q == LAST_WP) ? '0 : wp_q + 1'b1;
  end

  // lastWrite_q delays the completion pulse by one cycle so it lands after the final write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rfAddr_q    <= '0;
      chunk_q     <= '0;
      wp_q        <= '0;
      outData_q   <= '0;
      wEn_q       <= 1'b0;
      wAddr_q     <= '0;
      wNum_q      <= 1'b0;
      finish_q    <= 1'b0;
      lastWrite_q <= 1'b0;
    end else begin
      if (wEn_q && (wAddr_q == LAST_WP)) begin
        wNum_q <= ~wNum_q;
      end
      case (state_q)
        IDLE: begin
          wEn_q       <= 1'b0;
          finish_q    <= lastWrite_q;
          lastWrite_q <= 1'b0;
          if (conv_finish) begin
            state_q <= DONE;
          end else if (pe_psum_finish) begin
            state_q  <= RUN;
            rfAddr_q <= '0;
            chunk_q  <= '0;
          end
        end
        RUN: begin
          finish_q <= 1'b0;
          if (conv_finish) begin
            state_q     <= DONE;
            wEn_q       <= 1'b0;
            lastWrite_q <= 1'b0;
          end else begin
            outData_q <= chunkWord;
            wEn_q     <= 1'b1;
            wAddr_q   <= wp_q;
            wp_q      <= wp_d;
            if (chunk_q == LAST_CHUNK) begin
              chunk_q <= '0;
              if (rfAddr_q == LAST_RF) begin
                rfAddr_q    <= '0;
                state_q     <= IDLE;
                lastWrite_q <= 1'b1;
              end else begin
                rfAddr_q <= rfAddr_q + 1'b1;
              end
            end else begin
              chunk_q <= chunk_q + 1'b1;
            end
          end
        end
        DONE: begin
          wEn_q       <= 1'b0;
          finish_q    <= 1'b0;
          lastWrite_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psum_rf_addr      = rfAddr_q;
  assign su_add_finish     = finish_q;
  assign out_data          = outData_q;
  assign psum_gbf_w_en_out = wEn_q;
  assign psum_gbf_w_addr   = wAddr_q;
  assign psum_gbf_w_num    = wNum_q;

endmodule

// File: tb/tb_rel_psum_gbf_packer.sv
// Directed bench for rel_psum_gbf_packer: full drain passes, re-pulse, conv abort,
// reset abort, with expected GBF words computed from the PE value pattern.
module tb_rel_psum_gbf_packer;

  logic           clk = 1'b0;
  logic           reset;
  logic [4095:0]  psumOut;
  logic           peFinish;
  logic           convFinish;
  logic [1:0]     rfAddr;
  logic           suFinish;
  logic [511:0]   outData;
  logic           wEn;
  logic [4:0]     wAddr;
  logic           wNum;

  int checks = 0;
  int passed = 0;

  rel_psum_gbf_packer dut (
    .clk               (clk),
    .reset             (reset),
    .psum_out          (psumOut),
    .pe_psum_finish    (peFinish),
    .conv_finish       (convFinish),
    .psum_rf_addr      (rfAddr),
    .su_add_finish     (suFinish),
    .out_data          (outData),
    .psum_gbf_w_en_out (wEn),
    .psum_gbf_w_addr   (wAddr),
    .psum_gbf_w_num    (wNum)
  );

  always #5 clk = ~clk;

  // PE p at RF address a holds p + 256*a
  always_comb begin
    psumOut = '0;
    for (int p = 0; p < 256; p++) begin
      psumOut[p*16 +: 16] = 16'(p + 256 * int'(rfAddr));
    end
  end

  function automatic logic [511:0] expWord(input int n);
    logic [511:0] w;
    w = '0;
    for (int l = 0; l < 32; l++) begin
      w[l*16 +: 16] = 16'(32 * (n % 8) + l + 256 * (n / 8));
    end
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    if (observed === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pe, input logic conv, input logic rst);
    peFinish   = pe;
    convFinish = conv;
    reset      = rst;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wEn"},    512'(wEn),      512'(0));
    checkOutput({tag, "_wAddr"},  512'(wAddr),    512'(0));
    checkOutput({tag, "_wNum"},   512'(wNum),     512'(0));
    checkOutput({tag, "_data"},   outData,        512'(0));
    checkOutput({tag, "_finish"}, 512'(suFinish), 512'(0));
    checkOutput({tag, "_rfAddr"}, 512'(rfAddr),   512'(0));
  endtask

  // Pulses pe_psum_finish and watches 40 cycles; abortAt >= 0 aborts after that write.
  task automatic drainPass(input string tag, input int abortAt, input bit byReset,
                           input bit rePulse, input logic expNum);
    int  writes = 0;
    int  finishes = 0;
    int  finishCycle = -1;
    bit  aborted = 0;
    bit  postAbort = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (postAbort) begin
        postAbort = 0;
        if (byReset) checkAllZero({tag, "_rst"});
        else checkOutput({tag, "_convWEn"}, 512'(wEn), 512'(0));
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
      if (wEn) begin
        checkOutput({tag, "_wAddr"}, 512'(wAddr), 512'(writes));
        checkOutput({tag, "_wData"}, outData, expWord(writes));
        if (writes == abortAt) begin
          aborted = 1;
          postAbort = 1;
          applyStimulus(1'b0, !byReset, byReset);
        end
        writes++;
      end
      if (suFinish) begin
        finishes++;
        finishCycle = cyc;
      end
      if (abortAt < 0 && cyc == 12) checkOutput({tag, "_rfMid"}, 512'(rfAddr), 512'(1));
      if (rePulse && cyc == 5) peFinish = 1'b1;
      if (rePulse && cyc == 6) peFinish = 1'b0;
    end
    if (abortAt < 0) begin
      checkOutput({tag, "_writes"},   512'(writes),      512'(32));
      checkOutput({tag, "_finishes"}, 512'(finishes),    512'(1));
      checkOutput({tag, "_finCycle"}, 512'(finishCycle), 512'(33));
      checkOutput({tag, "_wNum"},     512'(wNum),        512'(expNum));
    end else begin
      checkOutput({tag, "_aborted"},  512'(aborted),     512'(1));
      checkOutput({tag, "_writes"},   512'(writes),      512'(abortAt + 1));
      checkOutput({tag, "_finishes"}, 512'(finishes),    512'(0));
    end
  endtask

  // Applies one cycle of the given inputs and confirms no activity follows.
  task automatic quietWindow(input string tag, input logic pe, input logic conv);
    int writes = 0;
    int finishes = 0;
    applyStimulus(pe, conv, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (wEn) writes++;
      if (suFinish) finishes++;
    end
    checkOutput({tag, "_writes"},   512'(writes),   512'(0));
    checkOutput({tag, "_finishes"}, 512'(finishes), 512'(0));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int idleWrites = 0;
    $display("[TB] starting rel_psum_gbf_packer bench");
    doReset();
    checkAllZero("reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wEn) idleWrites++;
    end
    checkOutput("idleWrites", 512'(idleWrites), 512'(0));
    checkAllZero("idle");

    drainPass("pass1", -1, 1'b0, 1'b0, 1'b1);
    drainPass("pass2", -1, 1'b0, 1'b0, 1'b0);
    drainPass("repulse", -1, 1'b0, 1'b1, 1'b1);

    drainPass("convAbort", 10, 1'b0, 1'b0, 1'b1);
    quietWindow("doneIgnorePe", 1'b1, 1'b0);
    doReset();
    quietWindow("simulConvPe", 1'b1, 1'b1);
    doReset();

    drainPass("rstAbort", 20, 1'b1, 1'b0, 1'b0);
    drainPass("afterRst", -1, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rel_psum_gbf_packer.md
Name: rel_psum_gbf_packer

Overview:
- Drain engine for the "all-relevant" psum case: every PE holds a distinct output, so no spatial reduction is done.
- After each PE-array psum pass, it walks every psum register-file address and slices the flat PE-array psum vector into GBF-width words.
- It streams those words into the double-buffered psum GBF and flips buffers whenever a buffer fills.
- It sits between gbf_pe_array (psum_rf_addr/psum_out) and the psum GBF write port.

Parameters:
- ROW, 16, PE array rows.
- COL, 16, PE array columns.
- DATA_BITWIDTH, 16, bits per psum.
- GBF_DATA_BITWIDTH, 512, psum GBF word width; must divide DATA_BITWIDTH*ROW*COL.
- PSUM_RF_ADDR_BITWIDTH, 2, per-PE psum RF address width (NRF = 2^PSUM_RF_ADDR_BITWIDTH entries).
- GBF_ADDR_BITWIDTH, 5, psum GBF address width.
- DEPTH, 32, psum GBF words per buffer.

Ports:
- clk, input, 1: single clock, all state updates on rising edge.
- reset, input, 1: synchronous, active-high.
- psum_out, input, DATA_BITWIDTH*ROW*COL: flat psums of all PEs at the current psum_rf_addr. PE p occupies bits [p*DATA_BITWIDTH +: DATA_BITWIDTH].
- pe_psum_finish, input, 1: PE array finished a psum pass; request to drain.
- conv_finish, input, 1: whole convolution done.
- psum_rf_addr, output, PSUM_RF_ADDR_BITWIDTH: RF address whose psums must be driven on psum_out.
- su_add_finish, output, 1: one-cycle pulse when a drain pass completes.
- out_data, output, GBF_DATA_BITWIDTH: GBF write data.
- psum_gbf_w_en_out, output, 1: GBF write enable.
- psum_gbf_w_addr, output, GBF_ADDR_BITWIDTH: GBF write address.
- psum_gbf_w_num, output, 1: active GBF buffer (0 = buf1, 1 = buf2).

Behaviour:
- Definitions:
  - NCH = DATA_BITWIDTH*ROW*COL/GBF_DATA_BITWIDTH (8 at defaults).
  - Words per pass = NCH*NRF (32 at defaults, equal to DEPTH).
- psum_out is combinational from psum_rf_addr and is sampled in the same cycle the address is presented.
- Reset (synchronous):
  - State = IDLE.
  - Outputs cleared: psum_rf_addr=0, chunk index=0, write pointer wp=0, out_data=0, psum_gbf_w_en_out=0, psum_gbf_w_addr=0, psum_gbf_w_num=0, su_add_finish=0.
  - Reset mid-drain aborts immediately with the same values.
- All outputs are registered.
- States:
  - IDLE:
    - w_en=0; su_add_finish=0 except for the single completion cycle.
    - If conv_finish=1, go to DONE.
    - Else if pe_psum_finish=1, go to RUN with psum_rf_addr=0 and chunk=0.
  - RUN, each cycle:
    - out_data <= psum_out[chunk*GBF_DATA_BITWIDTH +: GBF_DATA_BITWIDTH]; w_en <= 1; psum_gbf_w_addr <= wp; wp <= wp+1.
    - chunk increments. At chunk NCH-1, chunk -> 0 and psum_rf_addr increments.
    - After writing chunk NCH-1 of rf addr NRF-1: psum_rf_addr -> 0, state -> IDLE, and in the next cycle w_en=0 and su_add_finish=1 for exactly one cycle.
    - pe_psum_finish is ignored in RUN.
  - DONE: w_en=0, all outputs hold. Exit only by reset.
- Priority and events:
  - conv_finish in any state goes to DONE next cycle; an in-flight write pass is abandoned.
  - conv_finish has priority over a simultaneous pe_psum_finish.
- Timing: with pe_psum_finish sampled at edge k:
  - Writes occur at edges k+1..k+32 (defaults).
  - su_add_finish is high after edge k+33.
- Buffer management:
  - wp wraps from DEPTH-1 to 0.
  - In the cycle after the word at address DEPTH-1 is written, psum_gbf_w_num toggles.
  - At defaults, every complete pass toggles psum_gbf_w_num once, coincident with su_add_finish.
  - If words per pass is not equal to DEPTH, the toggle occurs at each wrap, independent of pass boundaries.
- Data: no arithmetic, only bit-exact slicing. Chunk c, word bit j = psum_out bit c*GBF_DATA_BITWIDTH+j.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs 0, psum_rf_addr=0, no writes.
2. Drive psum_out so PE p = p + 256*psum_rf_addr (16-bit); pulse pe_psum_finish once -> 32 consecutive writes at addresses 0..31.
   - Write n holds PEs 32*(n%8)..32*(n%8)+31 at rf addr n/8; e.g. write 9 lane 0 = 0x0120.
   - Then su_add_finish is a 1-cycle pulse and psum_gbf_w_num goes 0->1.
3. Second pe_psum_finish -> addresses restart at 0; psum_gbf_w_num returns to 0 at completion.
4. pe_psum_finish re-pulsed during RUN -> ignored: exactly 32 writes, a single su_add_finish.
5. conv_finish asserted after write 10 -> w_en low next cycle and no su_add_finish; later pe_psum_finish has no effect until reset. Simultaneous conv_finish and pe_psum_finish in IDLE -> DONE, no writes.
6. Reset asserted after write 20 -> next cycle all outputs 0; a new pe_psum_finish starts at w_addr 0 with w_num=0.
